// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    // Word-align and fold an address into the instruction memory span.
    function automatic logic [31:0] wrap_pc(input logic [31:0] addr, input logic [31:0] span);
        return {addr[31:2], 2'b00} % span;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, insn} entries with flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   wdata_i,
    output entry_t                   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // Keep the read pointer so the stale head word stays put until refilled.
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, fills the prefetch queue, feeds decode.
// Optional FETCH_PERF_EN adds free-running fetch/stall counters.
//
// state  | meaning
// WAIT   | first cycle after reset release, memory output not yet trusted
// RUN    | fetch one word per cycle while the queue has room
// HALTED | no new fetches, queue drains, redirects still move the PC
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stalled_o
`endif
);

    localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [31:0] PC_SPAN = 32'(IMEM_WORDS * WORD_BYTES);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    entry_t          hold_q;
    entry_t          q_head;
    entry_t          q_wdata;
    logic            q_full, q_empty;
    logic [CW-1:0]   q_count;
    logic            pop_raw, q_pop, push;

    assign imem_addr_o  = fetch_pc_q;
    assign inst_valid_o = ~q_empty;
    assign inst_o       = q_empty ? hold_q.insn : q_head.insn;
    assign inst_pc_o    = q_empty ? hold_q.pc   : q_head.pc;

    assign pop_raw = inst_valid_o & inst_ready_i;
    assign q_pop   = pop_raw & ~redirect_valid_i;
    assign push    = (state_q == RUN) & ~halt_i & ~redirect_valid_i
                   & ((q_count < DEPTH_C) | pop_raw);
    assign q_wdata = '{pc: fetch_pc_q, insn: imem_rdata_i};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (q_pop),
        .flush_i (redirect_valid_i),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            WAIT:    state_d = RUN;
            RUN:     if (halt_i)  state_d = HALTED;
            HALTED:  if (!halt_i) state_d = RUN;
            default: state_d = WAIT;
        endcase
        if (redirect_valid_i) begin
            fetch_pc_d = wrap_pc(redirect_pc_i, PC_SPAN);
        end else if (push) begin
            fetch_pc_d = wrap_pc(fetch_pc_q + 32'(WORD_BYTES), PC_SPAN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WAIT;
            fetch_pc_q <= RESET_PC;
            hold_q     <= '{pc: 32'h0, insn: NOP_INSN};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            // Remember the last visible head so outputs hold once the queue empties.
            if (!q_empty) begin
                hold_q <= q_head;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stalled_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stalled_q <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((state_q == RUN) && q_full && !pop_raw) begin
                perf_stalled_q <= perf_stalled_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stalled_o = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus queues expected pops, a monitor checks them.
module tb_fetch_controller;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalled;
`endif

    logic [31:0] mem [1024];
    entry_t      exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[11:2]];

    fetch_controller #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2),
        .IMEM_WORDS  (1024)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .halt_i           (halt)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o   (perf_fetched),
        .perf_stalled_o   (perf_stalled)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready && !redirect_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pop: got pc %h insn %h expected no pop", inst_pc, inst);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.insn) begin
                    n_err++;
                    $display("FAIL pop: got pc %h insn %h expected pc %h insn %h",
                             inst_pc, inst, e.pc, e.insn);
                end
            end
        end
    end

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        entry_t      e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc   = pc;
            e.insn = mem[pc[11:2]];
            exp_q.push_back(e);
            pc = (pc + 32'd4) % 32'd4096;
        end
    endtask

    task automatic drain(input logic [31:0] start, input int n);
        expect_seq(start, n);
        inst_ready = 1'b1;
        repeat (n) tick();
        inst_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic redirect_pulse(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Called with rst asserted, just after a rising edge.
    task automatic start_stream();
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        expect_seq(32'h0, 7);
        inst_ready = 1'b1;
        rst = 1'b1;
        chk("c0_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("c1_valid", {31'b0, inst_valid}, 32'd0);
        chk("c1_addr", imem_addr, 32'h0);
        tick();
        chk("c2_valid", {31'b0, inst_valid}, 32'd1);
        chk("c2_pc", inst_pc, 32'h0);
        repeat (7) tick();
        inst_ready = 1'b0;
        chk("stream_left", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd8);
        chk("perf_stalled", perf_stalled, 32'd0);
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]    = 32'h2008_0005;
        mem[1]    = 32'h2009_0003;
        mem[2]    = 32'h0109_5020;
        mem[3]    = 32'hAC0A_0000;
        mem[4]    = 32'h8C0B_0000;
        mem[5]    = 32'h012A_5822;
        mem[1023] = 32'hDEAD_BEEF;
        repeat (2) tick();

        // Stream from power-up
        start_stream();

        // Backpressure from a fresh start at 0
        redirect_pulse(32'h0);
        chk("bp_redir_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("bp_first_valid", {31'b0, inst_valid}, 32'd1);
        repeat (4) tick();
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_head", inst_pc, 32'h0);
        chk("bp_valid", {31'b0, inst_valid}, 32'd1);
        drain(32'h0, 6);

        // Redirect while full
        tick();
        chk("rd_full_addr", imem_addr, 32'h20);
        redirect_pulse(32'h0000_0012);
        chk("rd_valid0", {31'b0, inst_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h10);
        tick();
        chk("rd_valid1", {31'b0, inst_valid}, 32'd1);
        chk("rd_pc", inst_pc, 32'h10);
        chk("rd_insn", inst, 32'h8C0B_0000);
        drain(32'h10, 3);

        // Wrap at the end of memory
        redirect_pulse(32'h0000_0FFC);
        tick();
        chk("wrap_pc", inst_pc, 32'hFFC);
        chk("wrap_insn", inst, 32'hDEAD_BEEF);
        drain(32'hFFC, 3);

        // Halt: drain, freeze, redirect while halted, resume
        tick();
        halt = 1'b1;
        tick();
        chk("halt_addr", imem_addr, 32'h10);
        drain(32'h8, 2);
        chk("halt_valid", {31'b0, inst_valid}, 32'd0);
        chk("halt_addr_frozen", imem_addr, 32'h10);
        chk("halt_hold_pc", inst_pc, 32'hC);
        chk("halt_hold_insn", inst, 32'hAC0A_0000);
        redirect_pulse(32'h8);
        chk("halt_redir_addr", imem_addr, 32'h8);
        tick();
        chk("halt_redir_valid", {31'b0, inst_valid}, 32'd0);
        chk("halt_redir_addr2", imem_addr, 32'h8);
        halt = 1'b0;
        tick();
        chk("resume_valid0", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("resume_valid1", {31'b0, inst_valid}, 32'd1);
        chk("resume_pc", inst_pc, 32'h8);
        drain(32'h8, 2);

        // Asynchronous reset mid-stream with the queue full
        tick();
        chk("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", {31'b0, inst_valid}, 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        tick();
        start_stream();

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
